// File: rtl/perm_inverse_stream.sv
// perm_inverse_stream
// Collects one permutation frame (entry i = destination of source i), then
// streams the inverse permutation in destination order (beat j = source that
// feeds destination j). Frames with a repeated destination are flagged on
// every output beat through out_err.
module perm_inverse_stream #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_err
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    // Control state
    state_t         state_q,     state_d;
    logic [W-1:0]   in_idx_q,    in_idx_d;
    logic [W-1:0]   out_idx_q,   out_idx_d;
    logic [N-1:0]   seen_q,      seen_d;
    logic           dup_q,       dup_d;

    // Registered outputs
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic           out_last_q,  out_last_d;
    logic           out_err_q,   out_err_d;

    // Inverse table; entries are only trusted where seen is set
    logic [W-1:0]   tbl_q [N];
    logic           tbl_we;
    logic [W-1:0]   tbl_waddr;
    logic [W-1:0]   tbl_wdata;

    logic           in_fire;
    logic           out_fire;
    logic [W-1:0]   nxt_out_idx;

    assign in_fire     = in_valid & in_ready_q;
    assign out_fire    = out_valid_q & out_ready;
    assign nxt_out_idx = out_idx_q + 1'b1;

    // Next-state, table write and next-output computation for both phases
    always_comb begin
        state_d     = state_q;
        in_idx_d    = in_idx_q;
        out_idx_d   = out_idx_q;
        seen_d      = seen_q;
        dup_d       = dup_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        tbl_we      = 1'b0;
        tbl_waddr   = in_data;
        tbl_wdata   = in_idx_q;

        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    // A repeated destination simply overwrites: the later source wins
                    tbl_we            = 1'b1;
                    seen_d[in_data]   = 1'b1;
                    in_idx_d          = in_idx_q + 1'b1;
                    if (seen_q[in_data]) begin
                        dup_d = 1'b1;
                    end
                    if (in_idx_q == LAST_IDX) begin
                        state_d     = ST_EMIT;
                        out_idx_d   = '0;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        out_err_d   = dup_q | seen_q[in_data];
                        // Destination 0 may be written by this very beat, so
                        // bypass the table write that lands on the same edge.
                        if (in_data == '0) begin
                            out_data_d = in_idx_q;
                        end else if (seen_q[0]) begin
                            out_data_d = tbl_q[0];
                        end else begin
                            out_data_d = '0;
                        end
                    end
                end
            end

            ST_EMIT: begin
                if (out_fire) begin
                    if (out_idx_q == LAST_IDX) begin
                        state_d     = ST_LOAD;
                        in_idx_d    = '0;
                        out_idx_d   = '0;
                        seen_d      = '0;
                        dup_d       = 1'b0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
                        out_err_d   = 1'b0;
                    end else begin
                        // Unhit destinations (only possible with duplicates) read as 0
                        out_idx_d  = nxt_out_idx;
                        out_last_d = (nxt_out_idx == LAST_IDX);
                        out_data_d = seen_q[nxt_out_idx] ? tbl_q[nxt_out_idx] : '0;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // FSM and control registers; reset drops any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            in_idx_q    <= '0;
            out_idx_q   <= '0;
            seen_q      <= '0;
            dup_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_idx_q    <= in_idx_d;
            out_idx_q   <= out_idx_d;
            seen_q      <= seen_d;
            dup_q       <= dup_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    // Inverse table storage; no reset needed because seen masks stale entries
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_q[tbl_waddr] <= tbl_wdata;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_perm_inverse_stream.sv
// Testbench for perm_inverse_stream: directed frames with a scoreboard queue
// filled from a reference inverse model when each frame is sent.
module tb_perm_inverse_stream;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_err;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
        logic         err;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [W-1:0] frame [N];

    perm_inverse_stream #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one beat and wait (bounded) for its transfer; leaves in_valid high
    task automatic push_beat(input logic [W-1:0] v);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    // Send a full frame and push its expected inverse onto the scoreboard
    task automatic send_frame(input logic [W-1:0] p [N], input bit gaps, input bit hold);
        logic [W-1:0] inv [N];
        logic [N-1:0] hit;
        logic         dup;
        exp_t         e;
        hit = '0;
        dup = 1'b0;
        for (int i = 0; i < N; i++) begin
            inv[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (hit[p[i]]) dup = 1'b1;
            hit[p[i]] = 1'b1;
            inv[p[i]] = W'(i);
        end
        for (int j = 0; j < N; j++) begin
            e.d    = hit[j] ? inv[j] : '0;
            e.last = (j == N - 1);
            e.err  = dup;
            exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if (i == N - 1) chk("no_early_out_valid", {31'd0, out_valid}, 32'd0);
            push_beat(p[i]);
        end
        if (!hold) in_valid = 1'b0;
        chk("out_valid_after_last_in", {31'd0, out_valid}, 32'd1);
        chk("in_ready_low_in_emit", {31'd0, in_ready}, 32'd0);
    endtask

    // Receive n beats and compare against the scoreboard; optional stalls
    task automatic recv_beats(input int n, input bit stall);
        exp_t         e;
        logic [W-1:0] d0;
        logic         l0;
        logic         r0;
        int           t;
        e = '0;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
            chk("scoreboard_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (stall) begin
                out_ready = 1'b0;
                d0 = out_data;
                l0 = out_last;
                r0 = out_err;
                @(negedge clk);
                chk("stall_data_stable", {29'd0, out_data}, {29'd0, d0});
                chk("stall_last_stable", {31'd0, out_last}, {31'd0, l0});
                chk("stall_err_stable", {31'd0, out_err}, {31'd0, r0});
                chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
            end
            out_ready = 1'b1;
            chk("out_data", {29'd0, out_data}, {29'd0, e.d});
            chk("out_last", {31'd0, out_last}, {31'd0, e.last});
            chk("out_err", {31'd0, out_err}, {31'd0, e.err});
            chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            if (e.last) begin
                chk("in_ready_after_last_out", {31'd0, in_ready}, 32'd1);
                chk("out_valid_after_last_out", {31'd0, out_valid}, 32'd0);
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_out_data", {29'd0, out_data}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Identity frame, no backpressure
        out_ready = 1'b1;
        frame = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        send_frame(frame, 1'b0, 1'b0);
        recv_beats(N, 1'b0);

        // Rotation
        frame = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd5, 3'd6};
        send_frame(frame, 1'b0, 1'b0);
        recv_beats(N, 1'b0);

        // Reversal
        frame = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        send_frame(frame, 1'b0, 1'b0);
        recv_beats(N, 1'b0);

        // Duplicate destination, then clean frame clears the flag
        frame = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        send_frame(frame, 1'b0, 1'b0);
        recv_beats(N, 1'b0);
        frame = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        send_frame(frame, 1'b0, 1'b0);
        recv_beats(N, 1'b0);

        // Input gaps and output stalls
        frame = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd5, 3'd6};
        send_frame(frame, 1'b1, 1'b0);
        recv_beats(N, 1'b1);
        out_ready = 1'b1;

        // Reset after 5 accepted inputs; beats offered during reset are ignored
        for (int i = 0; i < 5; i++) begin
            push_beat(3'd7);
        end
        in_data = 3'd5;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs();
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        frame = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd5, 3'd4, 3'd7, 3'd6};
        send_frame(frame, 1'b0, 1'b0);
        recv_beats(N, 1'b0);

        // Reset after 3 outputs of a frame
        frame = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        send_frame(frame, 1'b0, 1'b0);
        recv_beats(3, 1'b0);
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        exp_q.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        frame = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd5, 3'd4, 3'd7, 3'd6};
        send_frame(frame, 1'b0, 1'b0);
        recv_beats(N, 1'b0);

        // Back-to-back frames with in_valid held high
        frame = '{3'd2, 3'd5, 3'd7, 3'd0, 3'd1, 3'd6, 3'd4, 3'd3};
        send_frame(frame, 1'b0, 1'b1);
        recv_beats(N, 1'b0);
        frame = '{3'd6, 3'd3, 3'd0, 3'd5, 3'd2, 3'd7, 3'd1, 3'd4};
        send_frame(frame, 1'b0, 1'b1);
        recv_beats(N, 1'b0);
        in_valid = 1'b0;

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
